pipe_latency_checker: RTL and testbench
=======================================

// Module: pipe_latency_checker
// PURPOSE
//  Downstream monitor for the 3-bit register-chain stage. Samples the stage input and
//  both chain outputs (blk, nblk) each cycle and measures each output's latency in clocks.
//  Latency is found by correlating each output against a history of the input.
//  Reports pass/fail against the expected latencies. Lab-bench monitor, not in datapath.
// PARAMETERS
//  WIDTH     3   sample width of in_sample/blk/nblk
//  MAX_LAT   7   largest lag tested (lags 0..MAX_LAT)
//  WINDOW    16  TRACK cycles over which a lag must match every cycle
//  EXP_BLK   1   expected blk latency
//  EXP_NBLK  4   expected nblk latency
// PORTS
//  clk        in   1      rising-edge clock, shared with the stage under test
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      begin a measurement; honoured only in IDLE
//  in_sample  in   WIDTH  stage input, same value the stage sees this cycle
//  blk        in   WIDTH  stage output A
//  nblk       in   WIDTH  stage output B
//  busy       out  1      high in FILL and TRACK
//  done       out  1      one-cycle pulse in DONE
//  blk_lat    out  LW     measured blk latency; LW = $clog2(MAX_LAT+1)
//  nblk_lat   out  LW     measured nblk latency
//  blk_found  out  1      some lag matched blk for the whole window
//  nblk_found out  1      some lag matched nblk for the whole window
//  pass       out  1      both found, blk_lat==EXP_BLK, nblk_lat==EXP_NBLK
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, all counters 0, history 0, every output 0.
//  - History: hist[k] = in_sample delayed k+1 clocks. It shifts every cycle in every state.
//  - Lag k matches at cycle t when out(t)==in(t-k). Lag 0 compares against live in_sample.
//  - FSM:
//    IDLE  -> FILL on start. Clear ok vectors to all-ones. Load cnt=0.
//    FILL  runs MAX_LAT cycles so the history is valid. It ignores compares, then goes to TRACK with cnt=0.
//    TRACK runs WINDOW cycles. Each cycle: ok_blk[k] &= (blk==h(k)) and ok_nblk[k] &= (nblk==h(k)) for k=0..MAX_LAT.
//          After the WINDOW-th compare it goes to DONE.
//    DONE  latches results, pulses done for one cycle, then returns to IDLE.
//  - Result encoding: *_lat = lowest set index of ok vector. *_found = |ok.
//    If none found, *_lat=0 and *_found=0.
//  - blk_lat, nblk_lat, blk_found, nblk_found and pass hold their value until the next DONE or reset.
//    They are updated only in DONE, so they are stable while busy.
//  - start while busy or in DONE: ignored, no restart.
//  - start asserted on the cycle DONE->IDLE: ignored. A new run needs start in IDLE.
//  - Ambiguity (e.g. constant input): all lags match and the lowest wins, so lat=0.
//    This is specified behaviour, not an error.
//  - rst_n low mid-FILL/TRACK: abort immediately, all outputs 0. No done pulse.
//  - Counters: cnt is $clog2(max(MAX_LAT,WINDOW)+1) bits and never wraps within a run.
// STRUCTURE
//  - Package pipe_check_pkg: FSM state encoding (IDLE=0, FILL=1, TRACK=2, DONE=3),
//    default WIDTH/MAX_LAT/WINDOW/EXP_* constants, LW width function.
//  - Sub-module lag_match_tracker (WIDTH, MAX_LAT), instantiated twice (blk, nblk):
//    holds the ok vector. Inputs clear/enable and the history bus. Outputs lowest-index and found.
//  - Top: history shift register, FSM, counter, result latches, pass logic.
// TESTING
//  1. Delay 1 on blk, delay 4 on nblk, 3-bit LFSR input, start -> done 1 cycle after the
//     MAX_LAT+WINDOW cycles of FILL+TRACK; blk_lat=1, nblk_lat=4, both found=1, pass=1.
//  2. Swap delays (blk=4, nblk=1), random input -> blk_lat=4, nblk_lat=1, pass=0.
//  3. in_sample held 3'b101 -> blk_lat=0, nblk_lat=0, found=1, pass=0.
//  4. nblk driven by an independent LFSR -> nblk_found=0, nblk_lat=0, pass=0; blk result still valid.
//  5. start pulsed again at TRACK cycle 5 -> ignored; single done at the normal time, results unchanged.
//  6. rst_n low at TRACK cycle 8 -> busy=0 and all outputs 0 at once, no done. A new start after
//     release gives the scenario-1 result.

Source files
------------

// File: rtl/pipe_check_pkg.sv
// Shared constants for the latency checker: FSM encoding, default
// parameter values and the width helpers used to size counters and results.
package pipe_check_pkg;

   localparam int DEF_WIDTH    = 3;
   localparam int DEF_MAX_LAT  = 7;
   localparam int DEF_WINDOW   = 16;
   localparam int DEF_EXP_BLK  = 1;
   localparam int DEF_EXP_NBLK = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Bits needed to hold a lag index 0..max_lat.
   function automatic int lat_width(input int max_lat);
      return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
   endfunction

   // Bits needed for a phase counter that must reach the larger of the two phases.
   function automatic int cnt_width(input int max_lat, input int window);
      int m;
      m = (max_lat > window) ? max_lat : window;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/lag_match_tracker.sv
// Keeps one "still matching" flag per candidate lag for a single chain output.
// A flag drops the first time the output disagrees with the delayed input for
// that lag. The lowest surviving lag and the any-survivor flag are reported as
// look-ahead values (what the flags will hold after the current edge), so the
// parent can capture the final result on the very edge of the last compare.
module lag_match_tracker
   import pipe_check_pkg::*;
#(
   parameter  int WIDTH   = DEF_WIDTH,
   parameter  int MAX_LAT = DEF_MAX_LAT,
   localparam int LW      = lat_width(MAX_LAT)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         enable,
   input  logic [WIDTH-1:0]             sample,
   input  logic [(MAX_LAT+1)*WIDTH-1:0] hist_bus,
   output logic [LW-1:0]                lowest,
   output logic                         found
);

   logic [MAX_LAT:0] ok;
   logic [MAX_LAT:0] ok_next;
   logic [MAX_LAT:0] match;

   // Compare the observed output against every candidate delayed input.
   always_comb begin
      match = '0;
      for (int k = 0; k <= MAX_LAT; k++) begin
         match[k] = (sample == hist_bus[k*WIDTH +: WIDTH]);
      end
   end

   // A new run re-arms every lag; during tracking a lag survives only while it keeps matching.
   always_comb begin
      ok_next = ok;
      if (clear) begin
         ok_next = '1;
      end else if (enable) begin
         ok_next = ok & match;
      end
   end

   // Hold the survivor flags between cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok <= '0;
      end else begin
         ok <= ok_next;
      end
   end

   // Lowest surviving lag wins, so an ambiguous (e.g. constant) input reports lag 0.
   always_comb begin
      lowest = '0;
      found  = |ok_next;
      for (int k = MAX_LAT; k >= 0; k--) begin
         if (ok_next[k]) begin
            lowest = LW'(k);
         end
      end
   end

endmodule

// File: rtl/pipe_latency_checker.sv
// Bench-side monitor for the 3-bit register chain. It keeps a short history of
// the stage input, waits until that history is full, then checks for WINDOW
// cycles which lag of the input each chain output reproduces exactly, and
// reports the measured latencies against the expected ones.
module pipe_latency_checker
   import pipe_check_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int MAX_LAT  = DEF_MAX_LAT,
   parameter  int WINDOW   = DEF_WINDOW,
   parameter  int EXP_BLK  = DEF_EXP_BLK,
   parameter  int EXP_NBLK = DEF_EXP_NBLK,
   localparam int LW       = lat_width(MAX_LAT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in_sample,
   input  logic [WIDTH-1:0] blk,
   input  logic [WIDTH-1:0] nblk,
   output logic             busy,
   output logic             done,
   output logic [LW-1:0]    blk_lat,
   output logic [LW-1:0]    nblk_lat,
   output logic             blk_found,
   output logic             nblk_found,
   output logic             pass
);

   localparam int            CW         = cnt_width(MAX_LAT, WINDOW);
   localparam logic [CW-1:0] FILL_LAST  = CW'(MAX_LAT - 1);
   localparam logic [CW-1:0] TRACK_LAST = CW'(WINDOW - 1);

   logic [1:0]                   state;
   logic [CW-1:0]                cnt;
   logic [WIDTH-1:0]             hist [MAX_LAT];
   logic [(MAX_LAT+1)*WIDTH-1:0] hist_bus;
   logic                         clear_ok;
   logic                         track_en;
   logic                         last_track;
   logic [LW-1:0]                blk_lat_nx;
   logic [LW-1:0]                nblk_lat_nx;
   logic                         blk_found_nx;
   logic                         nblk_found_nx;
   logic                         pass_nx;

   // Input history: slot k holds in_sample from k+1 clocks ago, shifting in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < MAX_LAT; k++) begin
            hist[k] <= '0;
         end
      end else begin
         for (int k = MAX_LAT - 1; k > 0; k--) begin
            hist[k] <= hist[k-1];
         end
         hist[0] <= in_sample;
      end
   end

   // Flatten lag candidates: lag 0 is the live input, lag k>0 is history slot k-1.
   always_comb begin
      hist_bus = '0;
      hist_bus[WIDTH-1:0] = in_sample;
      for (int k = 1; k <= MAX_LAT; k++) begin
         hist_bus[k*WIDTH +: WIDTH] = hist[k-1];
      end
   end

   assign clear_ok   = (state == ST_IDLE) && start;
   assign track_en   = (state == ST_TRACK);
   assign last_track = track_en && (cnt == TRACK_LAST);
   assign busy       = (state == ST_FILL) || (state == ST_TRACK);
   assign done       = (state == ST_DONE);

   // Run sequencing: fill the history, track for the window, report once, back to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (start) begin
                  state <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (cnt == FILL_LAST) begin
                  state <= ST_TRACK;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_TRACK: begin
               if (cnt == TRACK_LAST) begin
                  state <= ST_DONE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   lag_match_tracker #(
      .WIDTH   (WIDTH),
      .MAX_LAT (MAX_LAT)
   ) u_blk_tracker (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear_ok),
      .enable   (track_en),
      .sample   (blk),
      .hist_bus (hist_bus),
      .lowest   (blk_lat_nx),
      .found    (blk_found_nx)
   );

   lag_match_tracker #(
      .WIDTH   (WIDTH),
      .MAX_LAT (MAX_LAT)
   ) u_nblk_tracker (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear_ok),
      .enable   (track_en),
      .sample   (nblk),
      .hist_bus (hist_bus),
      .lowest   (nblk_lat_nx),
      .found    (nblk_found_nx)
   );

   assign pass_nx = blk_found_nx && nblk_found_nx &&
                    (blk_lat_nx == LW'(EXP_BLK)) && (nblk_lat_nx == LW'(EXP_NBLK));

   // Results change only when a run completes, so they are valid together with done and stable while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_lat    <= '0;
         nblk_lat   <= '0;
         blk_found  <= 1'b0;
         nblk_found <= 1'b0;
         pass       <= 1'b0;
      end else if (last_track) begin
         blk_lat    <= blk_found_nx  ? blk_lat_nx  : '0;
         nblk_lat   <= nblk_found_nx ? nblk_lat_nx : '0;
         blk_found  <= blk_found_nx;
         nblk_found <= nblk_found_nx;
         pass       <= pass_nx;
      end
   end

endmodule

// File: tb/tb_pipe_latency_checker.sv
// Self-checking bench for pipe_latency_checker. The bench models the register
// chain itself (configurable delays on blk/nblk), queues the expected result of
// each run when it is started, and compares when done appears.
module tb_pipe_latency_checker;

   localparam int W   = 3;
   localparam int ML  = 7;
   localparam int WIN = 16;
   localparam int LW  = 3;

   typedef struct {
      logic [LW-1:0] bl;
      logic [LW-1:0] nl;
      logic          bf;
      logic          nf;
      logic          ps;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  in_sample;
   logic [W-1:0]  blk;
   logic [W-1:0]  nblk;
   logic          busy;
   logic          done;
   logic [LW-1:0] blk_lat;
   logic [LW-1:0] nblk_lat;
   logic          blk_found;
   logic          nblk_found;
   logic          pass;

   int vectors     = 0;
   int miscompares = 0;

   exp_t         sb[$];
   exp_t         held;
   logic [W-1:0] dl [ML+1];
   int           in_mode;
   int           blk_dly;
   int           nblk_dly;
   bit           nblk_indep;
   logic [W-1:0] lfsr;
   logic [W-1:0] const_val;

   pipe_latency_checker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_sample  (in_sample),
      .blk        (blk),
      .nblk       (nblk),
      .busy       (busy),
      .done       (done),
      .blk_lat    (blk_lat),
      .nblk_lat   (nblk_lat),
      .blk_found  (blk_found),
      .nblk_found (nblk_found),
      .pass       (pass)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
      return {s[1:0], s[2] ^ s[1]};
   endfunction

   // One clock: model the chain registers, then present the next input and chain outputs.
   task automatic step();
      @(posedge clk);
      #1;
      for (int k = ML; k > 0; k--) dl[k] = dl[k-1];
      dl[0] = in_sample;
      case (in_mode)
         0:       begin lfsr = lfsr_next(lfsr); in_sample = lfsr; end
         1:       in_sample = W'($urandom_range(0, 7));
         default: in_sample = const_val;
      endcase
      blk  = (blk_dly == 0) ? in_sample : dl[blk_dly-1];
      nblk = nblk_indep ? W'($urandom_range(0, 7))
                        : ((nblk_dly == 0) ? in_sample : dl[nblk_dly-1]);
   endtask

   // Start a run, watch it, and score the queued expectation when done appears.
   task automatic run_and_score(input string name, input int restart_cyc, input bit start_in_done);
      exp_t e;
      int   done_cyc;
      done_cyc = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int cyc = 2; cyc <= 60; cyc++) begin
         step();
         if (restart_cyc != 0) start = (cyc == restart_cyc);
         if (cyc == 10) begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL %s busy_mid_run: got %b want 1", name, busy);
            end
            vectors++;
            if (blk_lat !== held.bl || nblk_lat !== held.nl || pass !== held.ps) begin
               miscompares++;
               $display("[TB] FAIL %s results_stable: got %0d/%0d/%b want %0d/%0d/%b",
                        name, blk_lat, nblk_lat, pass, held.bl, held.nl, held.ps);
            end
         end
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
      end
      start = start_in_done;
      e = sb.pop_front();
      vectors++;
      if (done_cyc != ML + WIN + 1) begin
         miscompares++;
         $display("[TB] FAIL %s done_cycle: got %0d want %0d", name, done_cyc, ML + WIN + 1);
      end
      vectors++;
      if (blk_lat !== e.bl) begin
         miscompares++;
         $display("[TB] FAIL %s blk_lat: got %0d want %0d", name, blk_lat, e.bl);
      end
      vectors++;
      if (nblk_lat !== e.nl) begin
         miscompares++;
         $display("[TB] FAIL %s nblk_lat: got %0d want %0d", name, nblk_lat, e.nl);
      end
      vectors++;
      if (blk_found !== e.bf || nblk_found !== e.nf) begin
         miscompares++;
         $display("[TB] FAIL %s found: got %b/%b want %b/%b", name, blk_found, nblk_found, e.bf, e.nf);
      end
      vectors++;
      if (pass !== e.ps) begin
         miscompares++;
         $display("[TB] FAIL %s pass: got %b want %b", name, pass, e.ps);
      end
      held = e;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s after_done[%0d]: got done=%b busy=%b want 0/0", name, i, done, busy);
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      vectors++;
      if ({busy, done, blk_found, nblk_found, pass} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got %b want 00000", {busy, done, blk_found, nblk_found, pass});
      end
      vectors++;
      if (blk_lat !== '0 || nblk_lat !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_lat: got %0d/%0d want 0/0", blk_lat, nblk_lat);
      end
      rst_n = 1'b1;
      repeat (10) step();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL idle_without_start: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_nominal();
      in_mode = 0; blk_dly = 1; nblk_dly = 4; nblk_indep = 0;
      repeat (10) step();
      sb.push_back('{bl: 3'd1, nl: 3'd4, bf: 1'b1, nf: 1'b1, ps: 1'b1});
      run_and_score("nominal", 0, 1'b0);
   endtask

   task automatic test_swapped();
      in_mode = 1; blk_dly = 4; nblk_dly = 1; nblk_indep = 0;
      repeat (10) step();
      sb.push_back('{bl: 3'd4, nl: 3'd1, bf: 1'b1, nf: 1'b1, ps: 1'b0});
      run_and_score("swapped", 0, 1'b1);
   endtask

   task automatic test_constant();
      in_mode = 2; const_val = 3'b101; blk_dly = 1; nblk_dly = 4; nblk_indep = 0;
      repeat (10) step();
      sb.push_back('{bl: 3'd0, nl: 3'd0, bf: 1'b1, nf: 1'b1, ps: 1'b0});
      run_and_score("constant", 0, 1'b0);
   endtask

   task automatic test_independent();
      in_mode = 0; blk_dly = 1; nblk_dly = 4; nblk_indep = 1;
      repeat (10) step();
      sb.push_back('{bl: 3'd1, nl: 3'd0, bf: 1'b1, nf: 1'b0, ps: 1'b0});
      run_and_score("independent", 0, 1'b0);
      nblk_indep = 0;
   endtask

   task automatic test_restart_ignored();
      in_mode = 0; blk_dly = 1; nblk_dly = 4; nblk_indep = 0;
      repeat (10) step();
      sb.push_back('{bl: 3'd1, nl: 3'd4, bf: 1'b1, nf: 1'b1, ps: 1'b1});
      run_and_score("restart_ignored", ML + 1 + 5, 1'b0);
   endtask

   task automatic test_reset_abort();
      in_mode = 0; blk_dly = 1; nblk_dly = 4; nblk_indep = 0;
      sb.push_back('{bl: 3'd1, nl: 3'd4, bf: 1'b1, nf: 1'b1, ps: 1'b1});
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (ML + 8) step();
      rst_n = 1'b0;
      #1;
      void'(sb.pop_front());
      vectors++;
      if ({busy, done, blk_found, nblk_found, pass} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_flags: got %b want 00000", {busy, done, blk_found, nblk_found, pass});
      end
      vectors++;
      if (blk_lat !== '0 || nblk_lat !== '0) begin
         miscompares++;
         $display("[TB] FAIL abort_lat: got %0d/%0d want 0/0", blk_lat, nblk_lat);
      end
      repeat (3) step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done[%0d]: got done=%b busy=%b want 0/0", i, done, busy);
         end
      end
      held = '{bl: 3'd0, nl: 3'd0, bf: 1'b0, nf: 1'b0, ps: 1'b0};
      sb.push_back('{bl: 3'd1, nl: 3'd4, bf: 1'b1, nf: 1'b1, ps: 1'b1});
      run_and_score("after_abort", 0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0;
      in_sample = '0; blk = '0; nblk = '0;
      for (int k = 0; k <= ML; k++) dl[k] = '0;
      in_mode = 0; blk_dly = 1; nblk_dly = 4; nblk_indep = 0;
      lfsr = 3'b001; const_val = 3'b101;
      held = '{bl: 3'd0, nl: 3'd0, bf: 1'b0, nf: 1'b0, ps: 1'b0};
      $display("[TB] pipe_latency_checker bench start");
      test_reset();
      test_nominal();
      test_swapped();
      test_constant();
      test_independent();
      test_restart_ignored();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
